batchnorm_fold_layer: RTL and testbench
=======================================

// Module: batchnorm_fold_layer
// PURPOSE
//  Folded (time-multiplexed) batch-normalisation stage: y[i] = sat(((x[i]*scale[i]) >>> NFRAC) + bias[i]).
//  Sits directly upstream of the ReLU activation layer; its output_data vector feeds relu input_data.
//  Processes LANES elements per cycle over SIZE/LANES cycles to trade DSP count for latency.
//  Valid/ready on both sides; the output vector is held stable until it is consumed.
// PARAMETERS
//  WIDTH  10  fixed-point word width (signed, two's complement)
//  NFRAC   5  fractional bits; applies to x, scale, bias and y (NFRAC < WIDTH)
//  SIZE   32  vector length; must match the downstream ReLU SIZE
//  LANES   4  parallel multiply lanes; SIZE % LANES == 0 (elaboration-time assert)
// PORTS
//  clk          in   1             rising-edge clock
//  rst_n        in   1             asynchronous, active-low reset
//  in_valid     in   1             input_data/scale/bias valid
//  in_ready     out  1             block idle, can accept a vector
//  input_data   in   WIDTH x SIZE  signed activations from the dense stage
//  scale        in   WIDTH x SIZE  signed per-channel folded gamma/sigma
//  bias         in   WIDTH x SIZE  signed per-channel folded beta - mu*scale
//  out_valid    out  1             output_data holds a complete result vector
//  out_ready    in   1             downstream accepts output_data
//  output_data  out  WIDTH x SIZE  signed normalised vector to the ReLU layer
// BEHAVIOUR
//  - Reset (rst_n low, any time, incl. mid-vector): state=IDLE, chunk counter=0, pipeline valids=0,
//    out_valid=0, output_data all 0, in_ready=0 while rst_n low; in_ready=1 on first edge after release.
//  - NCHUNK = SIZE/LANES. FSM states IDLE, RUN, DONE.
//  - IDLE: in_ready=1. Edge with in_valid&&in_ready captures input_data, scale, bias into an internal
//    vector register -> RUN, counter=0. Upstream may change its inputs after that edge.
//  - RUN: in_ready=0. Each cycle issues chunk k (elements k*LANES .. k*LANES+LANES-1) into a 2-stage
//    lane pipeline (stage 1: registered product; stage 2: shift, add, saturate, write output buffer).
//    Counter increments to NCHUNK-1, then pipeline drains; -> DONE when the last chunk is written.
//  - Latency: out_valid rises exactly NCHUNK+2 rising edges after the accepting edge (10 at defaults).
//  - DONE: out_valid=1, output_data stable. Edge with out_ready -> IDLE, out_valid=0. in_ready is 0
//    in DONE, so accept and release never coincide; next accept possible one cycle later.
//  - out_ready while out_valid=0 is ignored; in_valid outside IDLE is ignored (no capture).
//  - output_data updates only during RUN; between vectors it holds the last result.
//  - Arithmetic: product 2*WIDTH signed; arithmetic right shift by NFRAC (floor toward -inf);
//    bias sign-extended to 2*WIDTH; sum saturated to [-2^(WIDTH-1), 2^(WIDTH-1)-1]. No rounding.
//  - Throughput: one vector per NCHUNK+4 cycles with out_ready held high.
// STRUCTURE
//  - Shared package nn_fixed_pkg: fx_sat() saturation function, fx_mul_shift() helper,
//    bn_state_e enum {IDLE,RUN,DONE}; WIDTH/NFRAC defaults shared with the other layers.
//  - Sub-module bn_lane: one 2-stage multiply/shift/add/saturate lane with valid pass-through;
//    instantiated LANES times with a generate loop. FSM, counter, capture and output buffer in top.
// TESTING (defaults, 1.0 = 32)
//  1. x=32, scale=48, bias=16 on all elements -> every y=64; out_valid exactly 10 edges after accept.
//  2. x=300, scale=64, bias=0 -> 511 (pos sat); x=-300 -> -512 (neg sat); x=-1, scale=1 -> -1 (floor).
//  3. x[i]=i, scale=32, bias=-i -> all y=0; checks per-element channel indexing across all 8 chunks.
//  4. out_ready low 20 cycles in DONE -> out_valid/output_data stable, in_ready=0, extra in_valid ignored;
//     then out_ready=1 -> IDLE next edge, new vector accepted the following edge.
//  5. rst_n pulsed low in RUN chunk 4 -> out_valid=0, output_data=0 immediately; fresh vector after
//     release completes with correct values and nominal latency.
//  6. Back-to-back: 100 random vectors, in_valid/out_ready randomly toggled -> matches reference model.

Source files
------------

// File: rtl/nn_fixed_pkg.sv
// rtl/nn_fixed_pkg.sv - shared fixed-point types, defaults and helpers for the nn layers
package nn_fixed_pkg;

    localparam int FX_WIDTH = 10;
    localparam int FX_NFRAC = 5;
    localparam int FX_MAXW  = 32;

    // Wide enough to hold any product/sum of two FX_MAXW-bit words without overflow
    typedef logic signed [2*FX_MAXW-1:0] fx_wide_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } bn_state_e;

    // Drops the extra fractional bits of a full-precision product (floor toward -inf)
    function automatic fx_wide_t fx_mul_shift(input fx_wide_t prod, input int nfrac);
        return prod >>> nfrac;
    endfunction

    function automatic fx_wide_t fx_sat(input fx_wide_t v, input int width);
        fx_wide_t hi;
        fx_wide_t lo;
        hi = (fx_wide_t'(1) <<< (width - 1)) - fx_wide_t'(1);
        lo = -hi - fx_wide_t'(1);
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

endpackage

// File: rtl/bn_lane.sv
// rtl/bn_lane.sv - one 2-stage multiply / shift / bias-add / saturate lane
module bn_lane
    import nn_fixed_pkg::*;
#(
    parameter int WIDTH = FX_WIDTH,
    parameter int NFRAC = FX_NFRAC
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    valid_i,
    input  logic signed [WIDTH-1:0] x_i,
    input  logic signed [WIDTH-1:0] scale_i,
    input  logic signed [WIDTH-1:0] bias_i,
    output logic                    valid_o,
    output logic signed [WIDTH-1:0] y_o
);

    logic signed [2*WIDTH-1:0] prod_d, prod_q;
    logic signed [WIDTH-1:0]   bias_q;
    logic signed [WIDTH-1:0]   y_d, y_q;
    logic                      v1_q, v2_q;

    assign prod_d = $signed({{WIDTH{x_i[WIDTH-1]}}, x_i})
                  * $signed({{WIDTH{scale_i[WIDTH-1]}}, scale_i});

    // Bias travels with the product so stage 2 sees a matched pair
    assign y_d = WIDTH'(fx_sat(fx_mul_shift(fx_wide_t'(prod_q), NFRAC) + fx_wide_t'(bias_q), WIDTH));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_q <= '0;
            bias_q <= '0;
            v1_q   <= 1'b0;
            y_q    <= '0;
            v2_q   <= 1'b0;
        end else begin
            v1_q <= valid_i;
            v2_q <= v1_q;
            if (valid_i) begin
                prod_q <= prod_d;
                bias_q <= bias_i;
            end
            if (v1_q) begin
                y_q <= y_d;
            end
        end
    end

    assign valid_o = v2_q;
    assign y_o     = y_q;

endmodule

// File: rtl/batchnorm_fold_layer.sv
// rtl/batchnorm_fold_layer.sv - folded batch-norm stage: capture, chunk issue FSM, output buffer
module batchnorm_fold_layer
    import nn_fixed_pkg::*;
#(
    parameter int WIDTH = FX_WIDTH,
    parameter int NFRAC = FX_NFRAC,
    parameter int SIZE  = 32,
    parameter int LANES = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [SIZE-1:0][WIDTH-1:0]  input_data,
    input  logic [SIZE-1:0][WIDTH-1:0]  scale,
    input  logic [SIZE-1:0][WIDTH-1:0]  bias,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [SIZE-1:0][WIDTH-1:0]  output_data
);

    localparam int NCHUNK = SIZE / LANES;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int IW     = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

    if (SIZE % LANES != 0) begin : g_bad_lanes
        $error("batchnorm_fold_layer: SIZE must be a multiple of LANES");
    end

    bn_state_e                 state_q, state_d;
    logic [CW-1:0]             cnt_q, cnt_d;
    logic                      issue_q, issue_d;
    logic                      rdy_q;
    logic [CW-1:0]             idx1_q, idx2_q;
    logic [SIZE-1:0][WIDTH-1:0] x_q, s_q, b_q, out_q;

    logic [LANES-1:0]             lane_v;
    logic [LANES-1:0][WIDTH-1:0]  lane_x, lane_s, lane_b, lane_y;
    logic                         accept, y_v, last_wr;

    assign accept  = (state_q == IDLE) && in_valid && rdy_q;
    assign y_v     = &lane_v;
    assign last_wr = y_v && (idx2_q == LAST);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        issue_d = issue_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    issue_d = 1'b1;
                end
            end
            RUN: begin
                if (issue_q) begin
                    if (cnt_q == LAST) begin
                        issue_d = 1'b0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                if (last_wr) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // in_ready is registered so it stays low throughout reset and rises on the first edge after
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            issue_q <= 1'b0;
            rdy_q   <= 1'b0;
            idx1_q  <= '0;
            idx2_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            issue_q <= issue_d;
            rdy_q   <= (state_d == IDLE);
            if (issue_q) begin
                idx1_q <= cnt_q;
            end
            idx2_q <= idx1_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q <= '0;
            s_q <= '0;
            b_q <= '0;
        end else if (accept) begin
            x_q <= input_data;
            s_q <= scale;
            b_q <= bias;
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign lane_x[l] = x_q[IW'(int'(cnt_q) * LANES + l)];
        assign lane_s[l] = s_q[IW'(int'(cnt_q) * LANES + l)];
        assign lane_b[l] = b_q[IW'(int'(cnt_q) * LANES + l)];

        bn_lane #(
            .WIDTH (WIDTH),
            .NFRAC (NFRAC)
        ) u_lane (
            .clk     (clk),
            .rst_n   (rst_n),
            .valid_i (issue_q),
            .x_i     (lane_x[l]),
            .scale_i (lane_s[l]),
            .bias_i  (lane_b[l]),
            .valid_o (lane_v[l]),
            .y_o     (lane_y[l])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q <= '0;
        end else if (y_v) begin
            for (int l = 0; l < LANES; l++) begin
                out_q[IW'(int'(idx2_q) * LANES + l)] <= lane_y[l];
            end
        end
    end

    assign in_ready    = rdy_q;
    assign out_valid   = (state_q == DONE);
    assign output_data = out_q;

endmodule

// File: tb/tb_batchnorm_fold_layer.sv
// tb/tb_batchnorm_fold_layer.sv - self-checking bench for batchnorm_fold_layer
module tb_batchnorm_fold_layer;

    localparam int W  = 10;
    localparam int N  = 32;
    localparam int NV = 13;

    typedef logic [N-1:0][W-1:0] vec_t;
    typedef struct {
        logic [W-1:0] x;
        logic [W-1:0] s;
        logic [W-1:0] b;
        logic [W-1:0] y;
    } vt_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid = 1'b0;
    logic out_ready = 1'b0;
    logic in_ready, out_valid;
    vec_t in_x = '0, in_s = '0, in_b = '0, out_y;

    vec_t exp_q[$];
    vec_t last_exp = '0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   cyc = 0;
    bit   stop = 1'b0;
    vt_t  tab[NV];

    batchnorm_fold_layer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .input_data  (in_x),
        .scale       (in_s),
        .bias        (in_b),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .output_data (out_y)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic vt_t mk(input int x, input int s, input int b, input int y);
        vt_t r;
        r.x = W'(x);
        r.s = W'(s);
        r.b = W'(b);
        r.y = W'(y);
        return r;
    endfunction

    function automatic vec_t uni(input logic [W-1:0] v);
        vec_t r;
        for (int i = 0; i < N; i++) r[i] = v;
        return r;
    endfunction

    function automatic vec_t bn_model(input vec_t x, input vec_t s, input vec_t b);
        vec_t y;
        int xi, si, bi, p, v;
        for (int i = 0; i < N; i++) begin
            xi = int'($signed(x[i]));
            si = int'($signed(s[i]));
            bi = int'($signed(b[i]));
            p  = xi * si;
            v  = (p >>> 5) + bi;
            if (v > 511) v = 511;
            else if (v < -512) v = -512;
            y[i] = v[W-1:0];
        end
        return y;
    endfunction

    task automatic chk(input string name, input int got, input int expv);
        n_tests++;
        if (got != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, expv);
        end
    endtask

    task automatic chk_vec(input string name, input vec_t got, input vec_t expv);
        n_tests++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, expv);
        end
    endtask

    task automatic send(input vec_t x, input vec_t s, input vec_t b, input vec_t expv, output bit ok);
        ok = 1'b0;
        in_x = x;
        in_s = s;
        in_b = b;
        in_valid = 1'b1;
        for (int t = 0; t < 300 && !ok; t++) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(expv);
                ok = 1'b1;
            end
        end
        if (ok) begin
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!ok) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout: in_ready got 0 expected 1");
        end
    endtask

    task automatic drain(input int bound);
        int t;
        t = 0;
        while (exp_q.size() > 0 && t < bound) begin
            @(posedge clk);
            t++;
        end
        #1;
        chk("drain_pending", exp_q.size(), 0);
    endtask

    task automatic measure_latency(input string name);
        int lat;
        lat = 0;
        for (int t = 1; t <= 40; t++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                lat = t;
                break;
            end
        end
        chk(name, lat, 10);
    endtask

    // Scoreboard: every handshake on the output pops and compares one expected vector
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected: got %h expected no output", out_y);
            end else begin
                last_exp = exp_q.pop_front();
                if (out_y !== last_exp) begin
                    n_fail++;
                    $display("FAIL sb_data: got %h expected %h", out_y, last_exp);
                end
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout expected finish");
        n_fail++;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        bit   ok, hold_ok;
        int   rel;
        vec_t rx, rs, rb, vx, vs, vb;

        tab[0]  = mk(32, 48, 16, 64);
        tab[1]  = mk(300, 64, 0, 511);
        tab[2]  = mk(-300, 64, 0, -512);
        tab[3]  = mk(-1, 1, 0, -1);
        tab[4]  = mk(-3, 5, 0, -1);
        tab[5]  = mk(16, -16, 0, -8);
        tab[6]  = mk(-32, 32, -100, -132);
        tab[7]  = mk(511, 511, 511, 511);
        tab[8]  = mk(-512, -512, 0, 511);
        tab[9]  = mk(1, 1, -512, -512);
        tab[10] = mk(-512, 511, 0, -512);
        tab[11] = mk(100, 16, -20, 30);
        tab[12] = mk(0, 200, 7, 7);

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk_vec("rst_output", out_y, '0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("ready_after_release", int'(in_ready), 1);

        // Nominal vector with latency check
        out_ready = 1'b1;
        send(uni(W'(32)), uni(W'(48)), uni(W'(16)), uni(W'(64)), ok);
        measure_latency("latency_first");
        drain(100);

        // Uniform-vector table
        for (int k = 0; k < NV; k++) begin
            send(uni(tab[k].x), uni(tab[k].s), uni(tab[k].b), uni(tab[k].y), ok);
            drain(100);
        end

        // Per-element indexing across all chunks
        for (int i = 0; i < N; i++) begin
            vx[i] = W'(i);
            vs[i] = W'(32);
            vb[i] = W'(-i);
        end
        send(vx, vs, vb, '0, ok);
        drain(100);
        for (int i = 0; i < N; i++) begin
            vx[i] = W'(i - 16);
            vb[i] = W'(0);
        end
        send(vx, vs, vb, vx, ok);
        drain(100);
        repeat (3) @(posedge clk);
        #1;
        chk_vec("hold_between", out_y, vx);

        // Backpressure in DONE: A held, B ignored until release, then accepted
        out_ready = 1'b0;
        send(uni(W'(64)), uni(W'(32)), uni(W'(-5)), uni(W'(59)), ok);
        measure_latency("latency_stall");
        in_x = uni(W'(10));
        in_s = uni(W'(32));
        in_b = uni(W'(3));
        in_valid = 1'b1;
        hold_ok = 1'b1;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (!(out_valid && !in_ready && out_y == uni(W'(59)))) hold_ok = 1'b0;
        end
        chk("done_hold", int'(hold_ok), 1);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("release_out_valid", int'(out_valid), 0);
        chk("release_in_ready", int'(in_ready), 1);
        rel = cyc;
        send(uni(W'(10)), uni(W'(32)), uni(W'(3)), uni(W'(13)), ok);
        chk("accept_after_release", cyc - rel, 1);
        drain(100);

        // Reset during RUN chunk 4
        send(uni(W'(32)), uni(W'(32)), uni(W'(0)), uni(W'(32)), ok);
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_in_ready", int'(in_ready), 0);
        chk_vec("midrst_output", out_y, '0);
        if (exp_q.size() > 0) void'(exp_q.pop_back());
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_ready_after", int'(in_ready), 1);
        send(uni(W'(-40)), uni(W'(24)), uni(W'(2)), uni(W'(-28)), ok);
        measure_latency("latency_after_reset");
        drain(100);

        // Random back-to-back traffic against the reference model
        stop = 1'b0;
        fork
            begin
                for (int v = 0; v < 100; v++) begin
                    for (int i = 0; i < N; i++) begin
                        rx[i] = W'($urandom);
                        rs[i] = W'($urandom);
                        rb[i] = W'($urandom);
                    end
                    repeat ($urandom_range(0, 3)) begin
                        @(posedge clk);
                        #1;
                    end
                    send(rx, rs, rb, bn_model(rx, rs, rb), ok);
                end
                drain(3000);
                stop = 1'b1;
            end
            begin
                while (!stop) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join

        chk("sb_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
